// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// registers the returned word into IF/ID, gated by boot completion and downstream control.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_done_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StBoot: begin
        // Control inputs are meaningless before the image is loaded.
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        if (boot_done_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (jump_i) begin
          pc_d    = {jump_addr_i[31:2], 2'b00};
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end else if (hold_i) begin
          pc_d = pc_q;
        end else if (flush_i) begin
          pc_d    = pc_inc;
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end else begin
          pc_d     = pc_inc;
          pc_out_d = pc_q;
          inst_d   = rom_data_i;
          valid_d  = 1'b1;
          cnt_d    = cnt_q + 32'd1;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      pc_out_q <= 32'h0;
      inst_q   <= NOP_INST;
      valid_q  <= 1'b0;
      cnt_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rom_addr_o   = pc_q;
  assign pc_o         = pc_out_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign fetch_cnt_o  = cnt_q;

endmodule
